// File: rtl/lane_fifo_array.sv
// Array of LANES independent WIDTH-bit valid/ready FIFOs, each DEPTH entries deep.
// Optional per-lane popped-beat counter enabled by defining LANE_FIFO_CNT_EN.
module lane_fifo_array #(
   parameter int LANES = 4,
   parameter int WIDTH = 1,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [LANES-1:0]                       lane_en_i,
   input  logic [LANES-1:0]                       valid_i,
   output logic [LANES-1:0]                       ready_o,
   input  logic [LANES*WIDTH-1:0]                 data_i,
   output logic [LANES-1:0]                       valid_o,
   input  logic [LANES-1:0]                       ready_i,
   output logic [LANES*WIDTH-1:0]                 o,
`ifdef LANE_FIFO_CNT_EN
   output logic [LANES*CNT_W-1:0]                 cnt_o,
`endif
   output logic [LANES*($clog2(DEPTH)+1)-1:0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LW-1:0]    wr_q, wr_d;
         logic [LW-1:0]    rd_q, rd_d;
         logic [WIDTH-1:0] mem_q [DEPTH];
         logic             full, empty, push, pop;

         // Extra pointer MSB separates a full FIFO from an empty one.
         assign empty = (wr_q == rd_q);
         assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

         assign ready_o[gi] = lane_en_i[gi] & ~full;
         assign valid_o[gi] = ~empty;
         assign push        = valid_i[gi] & ready_o[gi];
         assign pop         = valid_o[gi] & ready_i[gi];

         always_comb begin
            wr_d = wr_q + {{AW{1'b0}}, push};
            rd_d = rd_q + {{AW{1'b0}}, pop};
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               wr_q <= '0;
               rd_q <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  mem_q[i] <= '0;
               end
            end else begin
               wr_q <= wr_d;
               rd_q <= rd_d;
               if (push) begin
                  mem_q[wr_q[AW-1:0]] <= data_i[gi*WIDTH +: WIDTH];
               end
            end
         end

         assign o[gi*WIDTH +: WIDTH] = mem_q[rd_q[AW-1:0]];
         assign level_o[gi*LW +: LW] = wr_q - rd_q;

`ifdef LANE_FIFO_CNT_EN
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (pop && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_o[gi*CNT_W +: CNT_W] = cnt_q;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_lane_fifo_array.sv
// Directed self-checking bench for lane_fifo_array (LANES=4, WIDTH=1, DEPTH=2, CNT_W=2).
module tb_lane_fifo_array;

   localparam int LANES = 4;
   localparam int WIDTH = 1;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;
   localparam int LW    = 2;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic [LANES-1:0]       lane_en_i;
   logic [LANES-1:0]       valid_i;
   logic [LANES-1:0]       ready_o;
   logic [LANES*WIDTH-1:0] data_i;
   logic [LANES-1:0]       valid_o;
   logic [LANES-1:0]       ready_i;
   logic [LANES*WIDTH-1:0] o;
   logic [LANES*LW-1:0]    level_o;
`ifdef LANE_FIFO_CNT_EN
   logic [LANES*CNT_W-1:0] cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   lane_fifo_array #(
      .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .lane_en_i(lane_en_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .o        (o),
`ifdef LANE_FIFO_CNT_EN
      .cnt_o    (cnt_o),
`endif
      .level_o  (level_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [LW-1:0] lvl(input int k);
      return level_o[k*LW +: LW];
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; lane_en_i = '0; valid_i = '0; ready_i = '0; data_i = '0;
      tick(); tick();
      rst_i = 1'b0; lane_en_i = 4'hF;
      #1;
      checks++;
      if (ready_o !== 4'hF) begin failures++; $display("FAIL reset_ready got=%h exp=F", ready_o); end
      checks++;
      if (valid_o !== 4'h0) begin failures++; $display("FAIL reset_valid got=%h exp=0", valid_o); end
      checks++;
      if (o !== 4'h0) begin failures++; $display("FAIL reset_o got=%h exp=0", o); end
      checks++;
      if (level_o !== 8'h00) begin failures++; $display("FAIL reset_level got=%h exp=00", level_o); end
      $display("test_reset ready=%h valid=%h o=%h level=%h", ready_o, valid_o, o, level_o);
   endtask

   task automatic test_fill_drain();
      logic [2:0] beats = 3'b101;   // beat order: bit0, bit1, bit2 = 1, 0, 1
      for (int i = 0; i < 3; i++) begin
         valid_i[2] = 1'b1; data_i[2] = beats[i];
         tick();
         $display("fill lane2 beat%0d data=%0b level=%0d ready=%0b", i, beats[i], lvl(2), ready_o[2]);
      end
      valid_i[2] = 1'b0;
      #1;
      checks++;
      if (lvl(2) !== 2'd2) begin failures++; $display("FAIL fill_level got=%0d exp=2", lvl(2)); end
      checks++;
      if (ready_o[2] !== 1'b0) begin failures++; $display("FAIL fill_ready got=%0b exp=0", ready_o[2]); end
      checks++;
      if (o[2] !== 1'b1) begin failures++; $display("FAIL fill_head got=%0b exp=1", o[2]); end
      ready_i[2] = 1'b1;
      tick();
      checks++;
      if (o[2] !== 1'b0 || valid_o[2] !== 1'b1) begin
         failures++; $display("FAIL drain_second got o=%0b v=%0b exp o=0 v=1", o[2], valid_o[2]);
      end
      tick();
      checks++;
      if (valid_o[2] !== 1'b0 || lvl(2) !== 2'd0) begin
         failures++; $display("FAIL drain_empty got v=%0b lvl=%0d exp v=0 lvl=0", valid_o[2], lvl(2));
      end
      ready_i[2] = 1'b0;
      $display("drain lane2 valid=%0b level=%0d", valid_o[2], lvl(2));
   endtask

   task automatic test_stream();
      logic [4:0] pat = 5'b11010;   // beats in order bit0..bit4 = 0,1,0,1,1
      valid_i[0] = 1'b1; data_i[0] = pat[0];
      tick();
      ready_i[0] = 1'b1;
      for (int i = 1; i < 5; i++) begin
         data_i[0] = pat[i];
         tick();
         checks++;
         if (o[0] !== pat[i] || lvl(0) !== 2'd1 || valid_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL stream_beat%0d got o=%0b lvl=%0d v=%0b exp o=%0b lvl=1 v=1",
                     i, o[0], lvl(0), valid_o[0], pat[i]);
         end
         $display("stream lane0 beat%0d o=%0b level=%0d", i, o[0], lvl(0));
      end
      valid_i[0] = 1'b0;
      tick();
      checks++;
      if (lvl(0) !== 2'd0 || valid_o[0] !== 1'b0) begin
         failures++; $display("FAIL stream_end got lvl=%0d v=%0b exp 0 0", lvl(0), valid_o[0]);
      end
      ready_i[0] = 1'b0;
   endtask

   task automatic test_lane_disable();
      valid_i[1] = 1'b1; data_i[1] = 1'b1;
      tick();
      data_i[1] = 1'b0;
      tick();
      lane_en_i[1] = 1'b0; ready_i[1] = 1'b1; data_i[1] = 1'b1;
      #1;
      checks++;
      if (ready_o[1] !== 1'b0 || lvl(1) !== 2'd2) begin
         failures++; $display("FAIL dis_full got rdy=%0b lvl=%0d exp 0 2", ready_o[1], lvl(1));
      end
      checks++;
      if (o[1] !== 1'b1) begin failures++; $display("FAIL dis_head got=%0b exp=1", o[1]); end
      tick();
      checks++;
      if (o[1] !== 1'b0 || lvl(1) !== 2'd1 || ready_o[1] !== 1'b0) begin
         failures++; $display("FAIL dis_drain1 got o=%0b lvl=%0d rdy=%0b exp 0 1 0", o[1], lvl(1), ready_o[1]);
      end
      tick();
      checks++;
      if (valid_o[1] !== 1'b0 || lvl(1) !== 2'd0) begin
         failures++; $display("FAIL dis_drain2 got v=%0b lvl=%0d exp 0 0", valid_o[1], lvl(1));
      end
      tick();
      checks++;
      if (valid_o[1] !== 1'b0 || lvl(1) !== 2'd0 || ready_o[1] !== 1'b0) begin
         failures++; $display("FAIL dis_ignore got v=%0b lvl=%0d rdy=%0b exp 0 0 0", valid_o[1], lvl(1), ready_o[1]);
      end
      $display("disable lane1 valid=%0b level=%0d ready=%0b", valid_o[1], lvl(1), ready_o[1]);
      valid_i[1] = 1'b0; ready_i[1] = 1'b0; lane_en_i[1] = 1'b1;
   endtask

   task automatic test_mid_reset();
      valid_i = 4'hF; data_i = 4'hF; ready_i = 4'h0;
      tick();
      valid_i = 4'h0;
      checks++;
      if (level_o !== 8'h55 || o !== 4'hF) begin
         failures++; $display("FAIL pre_reset got lvl=%h o=%h exp 55 F", level_o, o);
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      checks++;
      if (valid_o !== 4'h0 || level_o !== 8'h00 || o !== 4'h0 || ready_o !== 4'hF) begin
         failures++;
         $display("FAIL mid_reset got v=%h lvl=%h o=%h rdy=%h exp 0 00 0 F", valid_o, level_o, o, ready_o);
      end
      $display("mid_reset valid=%h level=%h o=%h", valid_o, level_o, o);
   endtask

`ifdef LANE_FIFO_CNT_EN
   task automatic test_counter();
      checks++;
      if (cnt_o !== 8'h00) begin failures++; $display("FAIL cnt_reset got=%h exp=00", cnt_o); end
      valid_i[3] = 1'b1; ready_i[3] = 1'b1; data_i[3] = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         $display("counter lane3 pop%0d cnt=%0d", i + 1, cnt_o[3*CNT_W +: CNT_W]);
         if (i == 1) begin
            checks++;
            if (cnt_o[3*CNT_W +: CNT_W] !== 2'd2) begin
               failures++; $display("FAIL cnt_two got=%0d exp=2", cnt_o[3*CNT_W +: CNT_W]);
            end
         end
      end
      valid_i[3] = 1'b0; ready_i[3] = 1'b0;
      checks++;
      if (cnt_o !== 8'hC0) begin failures++; $display("FAIL cnt_sat got=%h exp=C0", cnt_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_stream();
      test_lane_disable();
      test_mid_reset();
`ifdef LANE_FIFO_CNT_EN
      test_counter();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
